// File: rtl/game_pkg.sv
// Shared game-logic types and default sizing for the player death/respawn path.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    DYING   = 2'd2,
    RESPAWN = 2'd3
  } death_state_t;

  localparam int unsigned DEF_NUM_ENEMIES  = 16;
  localparam int unsigned DEF_FADE_FRAMES  = 32;
  localparam int unsigned DEF_GRACE_FRAMES = 8;
  localparam int unsigned DEF_CNT_W        = 10;

endpackage

// File: rtl/death_sequencer_sat_counter.sv
// Enable-increment counter that sticks at all-ones; async active-low clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/death_sequencer.sv
// Player death/respawn sequencer: freeze on enemy hit, fade countdown, one-frame respawn pulses,
// post-respawn collision grace and a saturating death counter for the HUD.
module death_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_ENEMIES  = DEF_NUM_ENEMIES,
  parameter int unsigned FADE_FRAMES  = DEF_FADE_FRAMES,
  parameter int unsigned GRACE_FRAMES = DEF_GRACE_FRAMES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                               frame_clk,
  input  logic                               Reset_n,
  input  logic                               game_active,
  input  logic                               level_load,
  input  logic [NUM_ENEMIES-1:0]             collision_vec,
  output logic                               player_freeze,
  output logic                               player_respawn,
  output logic                               start_enemies,
  output logic                               death_pulse,
  output logic [$clog2(FADE_FRAMES+1)-1:0]   fade_level,
  output logic [CNT_W-1:0]                   death_count,
  output logic [1:0]                         state_dbg
);

  localparam int unsigned FW = $clog2(FADE_FRAMES + 1);
  localparam int unsigned GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

  death_state_t  state, state_n;
  logic [FW-1:0] fade, fade_n;
  logic [GW-1:0] grace, grace_n;
  logic          hit;
  logic          count_en;

  assign hit = (|collision_vec) && (state == PLAY) && (grace == '0);

  // Next-state: inactive beats level load beats hit.
  always_comb begin
    state_n  = state;
    fade_n   = fade;
    grace_n  = grace;
    count_en = 1'b0;
    if (!game_active) begin
      state_n = IDLE;
      fade_n  = '0;
      grace_n = '0;
    end else if (state == IDLE) begin
      state_n = RESPAWN;
    end else if (level_load) begin
      state_n = RESPAWN;
      fade_n  = '0;
    end else begin
      case (state)
        PLAY: begin
          if (hit) begin
            state_n  = DYING;
            fade_n   = FW'(FADE_FRAMES);
            count_en = 1'b1;
          end else if (grace != '0) begin
            grace_n = grace - GW'(1);
          end
        end
        DYING: begin
          fade_n = fade - FW'(1);
          if (fade == FW'(1)) state_n = RESPAWN;
        end
        RESPAWN: begin
          state_n = PLAY;
          grace_n = GW'(GRACE_FRAMES);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every one of them leaves a flop glitch-free.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      fade           <= '0;
      grace          <= '0;
      player_freeze  <= 1'b1;
      player_respawn <= 1'b0;
      start_enemies  <= 1'b0;
      death_pulse    <= 1'b0;
    end else begin
      state          <= state_n;
      fade           <= fade_n;
      grace          <= grace_n;
      player_freeze  <= (state_n != PLAY);
      player_respawn <= (state_n == RESPAWN);
      start_enemies  <= (state_n == RESPAWN);
      death_pulse    <= count_en;
    end
  end

  assign fade_level = fade;
  assign state_dbg  = state;

  sat_counter #(.W(CNT_W)) u_death_cnt (
    .clk   (frame_clk),
    .rst_n (Reset_n),
    .en    (count_en),
    .count (death_count)
  );

endmodule

// File: tb/tb_death_sequencer.sv
// Randomised self-checking bench for death_sequencer (CNT_W=3 so saturation is reachable).
module tb_death_sequencer;

  localparam int unsigned FADE  = 32;
  localparam int unsigned GRACE = 8;
  localparam int unsigned CMAX  = 7;

  logic        frame_clk;
  logic        Reset_n;
  logic        game_active;
  logic        level_load;
  logic [15:0] collision_vec;
  logic        player_freeze;
  logic        player_respawn;
  logic        start_enemies;
  logic        death_pulse;
  logic [5:0]  fade_level;
  logic [2:0]  death_count;
  logic [1:0]  state_dbg;
  logic [14:0] act_vec;

  int n_cmp;
  int n_err;
  int n_deaths;

  // Reference model: mode 0=idle 1=play 2=dying 3=respawn, plain integer counters.
  int m_state, m_fade, m_grace, m_count;
  bit m_dp;

  death_sequencer #(
    .NUM_ENEMIES (16),
    .FADE_FRAMES (FADE),
    .GRACE_FRAMES(GRACE),
    .CNT_W       (3)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .game_active   (game_active),
    .level_load    (level_load),
    .collision_vec (collision_vec),
    .player_freeze (player_freeze),
    .player_respawn(player_respawn),
    .start_enemies (start_enemies),
    .death_pulse   (death_pulse),
    .fade_level    (fade_level),
    .death_count   (death_count),
    .state_dbg     (state_dbg)
  );

  assign act_vec = {state_dbg, player_freeze, player_respawn, start_enemies, death_pulse,
                    fade_level, death_count};

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  function automatic void model_reset();
    m_state = 0; m_fade = 0; m_grace = 0; m_count = 0; m_dp = 1'b0;
  endfunction

  function automatic void model_edge(input logic ga, input logic ll, input logic [15:0] cv);
    m_dp = 1'b0;
    if (!ga) begin
      m_state = 0; m_fade = 0; m_grace = 0;
    end else if (m_state == 0) begin
      m_state = 3;
    end else if (ll) begin
      m_state = 3; m_fade = 0;
    end else if (m_state == 1) begin
      if (cv != 16'h0 && m_grace == 0) begin
        m_state = 2; m_fade = FADE; m_dp = 1'b1;
        if (m_count < CMAX) m_count++;
      end else if (m_grace > 0) begin
        m_grace--;
      end
    end else if (m_state == 2) begin
      m_fade--;
      if (m_fade == 0) m_state = 3;
    end else begin
      m_state = 1; m_grace = GRACE;
    end
  endfunction

  function automatic logic [14:0] exp_vec();
    return {2'(m_state), (m_state != 1), (m_state == 3), (m_state == 3), m_dp,
            6'(m_fade), 3'(m_count)};
  endfunction

  function automatic logic [15:0] rnd_hit();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == 16'h0) v = 16'h8000;
    return v;
  endfunction

  task automatic step(input logic ga, input logic ll, input logic [15:0] cv);
    game_active   = ga;
    level_load    = ll;
    collision_vec = cv;
    @(posedge frame_clk);
    model_edge(ga, ll, cv);
    #1;
    if (death_pulse === 1'b1) n_deaths++;
  endtask

  task automatic run_to_open_play();
    int n;
    n = 0;
    while (!(m_state == 1 && m_grace == 0) && n < 200) begin
      step(1'b1, 1'b0, 16'h0);
      n++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL to_play: got %h expected %h", act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (!(m_state == 1 && m_grace == 0)) begin
      n_err++;
      $display("FAIL to_play_timeout: got %0d steps expected < 200", n);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; game_active = 1'b0; level_load = 1'b0; collision_vec = 16'h0;
    model_reset();
    #12;
    n_cmp++;
    if (act_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", act_vec, exp_vec());
    end
    @(negedge frame_clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'($urandom));
      n_cmp++;
      if (act_vec !== 15'b00_1_0_0_0_000000_000) begin
        n_err++;
        $display("FAIL reset_idle: got %h expected %h", act_vec, 15'b00_1_0_0_0_000000_000);
      end
    end
  endtask

  task automatic test_start();
    step(1'b1, 1'b0, 16'h0);
    n_cmp++;
    if ({state_dbg, player_respawn, start_enemies, player_freeze} !== 5'b11_1_1_1) begin
      n_err++;
      $display("FAIL start_respawn: got %b expected %b",
               {state_dbg, player_respawn, start_enemies, player_freeze}, 5'b11111);
    end
    step(1'b1, 1'b0, 16'h0);
    n_cmp++;
    if ({state_dbg, player_respawn, start_enemies, player_freeze} !== 5'b01_0_0_0) begin
      n_err++;
      $display("FAIL start_play: got %b expected %b",
               {state_dbg, player_respawn, start_enemies, player_freeze}, 5'b01000);
    end
  endtask

  task automatic test_death();
    int resp_at;
    int pulses;
    run_to_open_play();
    step(1'b1, 1'b0, 16'h0009);
    n_cmp++;
    if ({state_dbg, death_pulse, fade_level, death_count} !== {2'd2, 1'b1, 6'd32, 3'd1}) begin
      n_err++;
      $display("FAIL death_entry: got %h expected %h",
               {state_dbg, death_pulse, fade_level, death_count}, {2'd2, 1'b1, 6'd32, 3'd1});
    end
    resp_at = 0;
    pulses  = 0;
    for (int k = 1; k <= 40 && resp_at == 0; k++) begin
      step(1'b1, 1'b0, rnd_hit());
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL death_fade k=%0d: got %h expected %h", k, act_vec, exp_vec());
      end
      if (death_pulse === 1'b1) pulses++;
      if (player_respawn === 1'b1) resp_at = k;
    end
    n_cmp++;
    if (resp_at != int'(FADE) || pulses != 0) begin
      n_err++;
      $display("FAIL death_latency: got respawn at %0d extra pulses %0d expected %0d and 0",
               resp_at, pulses, FADE);
    end
  endtask

  task automatic test_grace();
    int hit_at;
    step(1'b1, 1'b0, 16'h0001);
    hit_at = 0;
    for (int i = 1; i <= 12 && hit_at == 0; i++) begin
      step(1'b1, 1'b0, 16'h0001);
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL grace_frame i=%0d: got %h expected %h", i, act_vec, exp_vec());
      end
      if (death_pulse === 1'b1) hit_at = i;
    end
    n_cmp++;
    if (hit_at != int'(GRACE) + 1 || death_count !== 3'd2) begin
      n_err++;
      $display("FAIL grace_hit: got frame %0d count %0d expected frame %0d count 2",
               hit_at, death_count, GRACE + 1);
    end
  endtask

  task automatic test_level_load();
    run_to_open_play();
    step(1'b1, 1'b1, rnd_hit());
    n_cmp++;
    if ({state_dbg, death_pulse, player_freeze, death_count} !== {2'd3, 1'b0, 1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL level_load_hit: got %h expected %h",
               {state_dbg, death_pulse, player_freeze, death_count}, {2'd3, 1'b0, 1'b1, 3'd2});
    end
    run_to_open_play();
    step(1'b1, 1'b0, rnd_hit());
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h0);
    n_cmp++;
    if ({state_dbg, fade_level, death_count} !== {2'd3, 6'd0, 3'd3}) begin
      n_err++;
      $display("FAIL level_load_dying: got %h expected %h",
               {state_dbg, fade_level, death_count}, {2'd3, 6'd0, 3'd3});
    end
  endtask

  task automatic test_saturation();
    int n;
    n = 0;
    while (n_deaths < 9 && n < 2000) begin
      step(1'b1, 1'b0, rnd_hit());
      n++;
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL sat_step: got %h expected %h", act_vec, exp_vec());
      end
    end
    n_cmp++;
    if (n_deaths != 9 || death_count !== 3'd7) begin
      n_err++;
      $display("FAIL saturation: got deaths %0d count %0d expected 9 and 7", n_deaths, death_count);
    end
  endtask

  task automatic test_abort();
    run_to_open_play();
    step(1'b1, 1'b0, rnd_hit());
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd_hit());
    step(1'b0, 1'b0, rnd_hit());
    n_cmp++;
    if (act_vec !== {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 3'd7}) begin
      n_err++;
      $display("FAIL abort_dying: got %h expected %h", act_vec,
               {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 3'd7});
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'($urandom));
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL abort_idle: got %h expected %h", act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic        ga, ll;
    logic [15:0] cv;
    for (int i = 0; i < 800; i++) begin
      ga = ($urandom_range(0, 49) != 0);
      ll = ($urandom_range(0, 39) == 0);
      cv = ($urandom_range(0, 3) == 0) ? rnd_hit() : 16'h0;
      step(ga, ll, cv);
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random i=%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    run_to_open_play();
    step(1'b1, 1'b0, rnd_hit());
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (act_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", act_vec, exp_vec());
    end
    @(negedge frame_clk);
    Reset_n = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    n_cmp++;
    if (act_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL post_reset: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_deaths = 0;
    test_reset();
    test_start();
    test_death();
    test_grace();
    test_level_load();
    test_saturation();
    test_abort();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
